// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the opcode constants decoded by the control FSM, the 2-bit ULAOp
// classes sent to the ALU-control decoder, and the FSM state type.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // 2'b11 is reserved and never driven.
  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  // Encodings are visible on state_o, so they are fixed explicitly.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StRwb    = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12
  } state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Memory handshake watchdog.
// Counts consecutive cycles spent waiting on a memory access that has not
// completed. expire is raised combinationally on the MEM_TIMEOUT-th such cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   waiting    : FSM is in a state that waits on memory
//   ready      : memory completed the access this cycle
//   expire     : timeout reached this cycle (ready not seen)
module mem_watchdog #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ready,
  output logic expire
);

  logic [TW-1:0] r_count;
  logic          w_expire;

  // r_count holds the stalled cycles already elapsed, so this cycle is the
  // MEM_TIMEOUT-th one when it equals MEM_TIMEOUT-1. ready wins the tie.
  always_comb begin
    w_expire = waiting && !ready && (r_count == TW'(MEM_TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!waiting || ready || w_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = w_expire;

endmodule

// File: rtl/ulacontrole_multiciclo.sv
// Main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, drives datapath enables and
// the ULAOp class, stalls on mem_ready, and raises sticky illegal_op / bus_err.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   opcode, mem_ready : IR[31:26] and memory-completion handshake
//   PCWrite..ULAOp    : datapath control (Moore, except stall-gated enables)
//   state_o           : current state encoding, for debug
//   illegal_op        : sticky, unknown opcode seen
//   bus_err           : sticky, memory timeout
module ulacontrole_multiciclo
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TW          = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ULASrcA,
  output logic [1:0] ULASrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ULAOp,
  output logic [3:0] state_o,
  output logic       illegal_op,
  output logic       bus_err
);

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   r_bus_err;
  logic   w_set_illegal;
  logic   w_waiting;
  logic   w_expire;

  assign w_waiting = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TW         (TW)
  ) u_mem_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .waiting(w_waiting),
    .ready  (mem_ready),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_set_illegal;
      r_bus_err <= r_bus_err | w_expire;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ULASrcA       = 1'b0;
    ULASrcB       = 2'b00;
    PCSource      = 2'b00;
    ULAOp         = ULA_ADD;
    case (r_state)
      StIdle: w_next = StFetch;
      StFetch: begin
        MemRead = 1'b1;
        ULASrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)     w_next = StDecode;
        else if (w_expire) w_next = StIdle;
      end
      StDecode: begin
        // ALU precomputes the branch target while the opcode is decoded.
        ULASrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = StMemAdr;
          OP_RTYPE:     w_next = StExec;
          OP_BEQ:       w_next = StBranch;
          OP_ADDI:      w_next = StAddiEx;
          OP_J:         w_next = StJump;
          default: begin
            // PC was already advanced in FETCH, so the instruction is skipped.
            w_set_illegal = 1'b1;
            w_next        = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        // opcode is re-sampled here; if it no longer names a memory op,
        // treat it as illegal rather than guess a direction.
        if (opcode == OP_LW) begin
          w_next = StMemRd;
        end else if (opcode == OP_SW) begin
          w_next = StMemWr;
        end else begin
          w_set_illegal = 1'b1;
          w_next        = StFetch;
        end
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)     w_next = StMemWb;
        else if (w_expire) w_next = StIdle;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = StFetch;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready)     w_next = StFetch;
        else if (w_expire) w_next = StIdle;
      end
      StExec: begin
        ULASrcA = 1'b1;
        ULAOp   = ULA_FUNCT;
        w_next  = StRwb;
      end
      StRwb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_next   = StFetch;
      end
      StBranch: begin
        ULASrcA     = 1'b1;
        ULAOp       = ULA_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_next      = StFetch;
      end
      StAddiEx: begin
        ULASrcA = 1'b1;
        ULASrcB = 2'b10;
        w_next  = StAddiWb;
      end
      StAddiWb: begin
        RegWrite = 1'b1;
        w_next   = StFetch;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = StFetch;
      end
      default: w_next = StIdle;
    endcase
  end

  assign state_o    = r_state;
  assign illegal_op = r_illegal;
  assign bus_err    = r_bus_err;

endmodule

// File: doc/ulacontrole_multiciclo.md
Name: ulacontrole_multiciclo

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the IR opcode and sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath enables and the 2-bit ULAOp consumed by the ALU-control decoder: 00 add, 01 subtract, 10 use funct; 11 is never emitted.
- Stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 15: max consecutive cycles waiting on mem_ready before bus_err is raised.
- TW, 4: width of the timeout counter; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- mem_ready  in  1  memory completed the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU zero (beq).
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write.
- ULASrcA  out  1  ALU A input: 0 = PC, 1 = A.
- ULASrcB  out  2  ALU B input: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- PCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ULAOp  out  2  operation class sent to the ALU-control decoder.
- state_o  out  4  current state, for debug.
- illegal_op  out  1  sticky; set on an unknown opcode.
- bus_err  out  1  sticky; set on a memory timeout.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; timeout counter = 0; illegal_op = 0; bus_err = 0.
  - All outputs 0; state_o = 0.
- State encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6.
  - EXEC = 7, RWB = 8, BRANCH = 9, ADDIEX = 10, ADDIWB = 11, JUMP = 12.
  - 13–15 are unreachable; if ever entered, next state is IDLE.
- Outputs are Moore decodes of state, except the stall-gated enables in FETCH and the memory states. Any signal not listed for a state is 0.
- IDLE: all outputs 0; next state FETCH.
- FETCH:
  - MemRead = 1, IorD = 0, ULASrcA = 0, ULASrcB = 01, ULAOp = 00.
  - IRWrite and PCWrite = mem_ready, PCSource = 00.
  - If mem_ready, next state DECODE; otherwise stay in FETCH.
- DECODE:
  - ULASrcA = 0, ULASrcB = 11, ULAOp = 00 (branch target precompute).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> set illegal_op, go to FETCH (instruction skipped; PC already advanced).
- MEMADR: ULASrcA = 1, ULASrcB = 10, ULAOp = 00; next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead = 1, IorD = 1; stall until mem_ready, then MEMWB.
- MEMWB: RegWrite = 1, MemtoReg = 1, RegDst = 0; next state FETCH.
- MEMWR: MemWrite = 1, IorD = 1; stall until mem_ready, then FETCH.
- EXEC: ULASrcA = 1, ULASrcB = 00, ULAOp = 10; next state RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0; next state FETCH.
- BRANCH: ULASrcA = 1, ULASrcB = 00, ULAOp = 01, PCWriteCond = 1, PCSource = 01; next state FETCH.
- ADDIEX: ULASrcA = 1, ULASrcB = 10, ULAOp = 00; next state ADDIWB.
- ADDIWB: RegWrite = 1, RegDst = 0, MemtoReg = 0; next state FETCH.
- JUMP: PCWrite = 1, PCSource = 10; next state FETCH.
- Timeout counter:
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready = 0.
  - Clears on mem_ready = 1 or on leaving those states.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: set bus_err, go to IDLE, clear the counter.
  - mem_ready on the same cycle as the timeout wins; no error is raised.
- Sticky flags: illegal_op and bus_err clear only on reset.
- Opcode sampling: opcode is read only in DECODE and MEMADR; it is ignored in all other states.
- Reset asserted mid-instruction: immediate return to IDLE. No write enable may glitch high while rst_n = 0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ULAOp constants (ULA_ADD = 00, ULA_SUB = 01, ULA_FUNCT = 10);
  - the state enum.
- The timeout counter is a natural sub-module, mem_watchdog (inputs: clk, rst_n, waiting, ready; output: expire).
- Everything else stays in one FSM module.

Test Plan:
- Reset then release with mem_ready = 1, opcode = 000000:
  - states IDLE -> FETCH -> DECODE -> EXEC -> RWB -> FETCH;
  - ULAOp = 10 in EXEC; RegWrite = 1 and RegDst = 1 in RWB.
- lw (100011), mem_ready low for 3 cycles in MEMRD:
  - MEMRD held for exactly 3 extra cycles, MemRead = 1, IorD = 1;
  - then MEMWB with MemtoReg = 1; bus_err stays 0.
- beq (000100): BRANCH shows ULAOp = 01, PCWriteCond = 1, PCSource = 01; instruction completes in 3 cycles.
- opcode = 111111: DECODE -> FETCH and illegal_op goes to 1 and stays 1 through a following addi (ADDIEX ULAOp = 00, ULASrcB = 10).
- mem_ready held 0 in FETCH: bus_err rises after 15 waiting cycles, state goes to IDLE, then the FSM restarts FETCH.
- rst_n pulsed low during MEMWR: all outputs immediately 0, MemWrite never asserted afterward, state_o = 0.
